// File: rtl/tinker_fetch_queue.sv
// tinker_fetch_queue: sequential 32-bit instruction fetch feeding an in-order {word, pc} queue toward decode.
// Latency: a response accepted in cycle N is presented on instValid in cycle N+1; there is no bypass path.
// Backpressure: requests are credit-limited so queued + in-flight never exceeds DEPTH; redirect flushes and restarts.
// Ports: clk, reset (async active-low); memReqValid/memReqReady/memReqAddr request channel;
//        memRespValid/memRespData in-order responses; instValid/instReady/instWord/instPc head of queue;
//        redirectValid/redirectPc flush and restart fetch at a new word-aligned PC.
module tinker_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        memReqValid,
   input  logic        memReqReady,
   output logic [31:0] memReqAddr,
   input  logic        memRespValid,
   input  logic [31:0] memRespData,
   output logic        instValid,
   input  logic        instReady,
   output logic [31:0] instWord,
   output logic [31:0] instPc,
   input  logic        redirectValid,
   input  logic [31:0] redirectPc
);
   localparam int          PW        = $clog2(DEPTH);
   localparam int          CW        = PW + 1;
   localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   q_word [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] in_flight;
   logic [CW-1:0] drop_count;

   logic          req_fire;
   logic          resp_take;
   logic          push;
   logic          pop;
   logic [31:0]   redirect_pc_aligned;
   logic          redirect_low_unused;

   // Low two bits of the redirect target are forced to zero.
   assign redirect_pc_aligned = {redirectPc[31:2], 2'b00};
   assign redirect_low_unused = ^redirectPc[1:0];

   // Credit check is done one bit wider so occupancy + in_flight cannot wrap.
   // Gated by reset so no request is offered while reset is held.
   assign memReqValid = reset && !redirectValid &&
                        (({1'b0, occupancy} + {1'b0, in_flight}) < DEPTH_EXT);
   assign memReqAddr  = fetch_pc;

   assign instValid   = reset && !redirectValid && (occupancy != '0);
   assign instWord    = q_word[head];
   assign instPc      = q_pc[head];

   assign req_fire    = memReqValid && memReqReady;
   // A response with nothing outstanding is a protocol violation and is ignored.
   assign resp_take   = memRespValid && (in_flight != '0);
   assign push        = resp_take && !redirectValid && (drop_count == '0);
   assign pop         = instValid && instReady;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc   <= RESET_PC;
         resp_pc    <= RESET_PC;
         head       <= '0;
         tail       <= '0;
         occupancy  <= '0;
         in_flight  <= '0;
         drop_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_word[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else if (redirectValid) begin
         // Flush: everything still outstanding after this cycle's response is stale.
         fetch_pc   <= redirect_pc_aligned;
         resp_pc    <= redirect_pc_aligned;
         head       <= '0;
         tail       <= '0;
         occupancy  <= '0;
         in_flight  <= in_flight - CW'(resp_take);
         drop_count <= in_flight - CW'(resp_take);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         in_flight <= in_flight + CW'(req_fire) - CW'(resp_take);
         if (resp_take && (drop_count != '0)) begin
            drop_count <= drop_count - CW'(1);
         end
         if (push) begin
            q_word[tail] <= memRespData;
            q_pc[tail]   <= resp_pc;
            tail         <= tail + PW'(1);
            resp_pc      <= resp_pc + 32'd4;
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         occupancy <= occupancy + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: doc/tinker_fetch_queue.md
# tinker_fetch_queue

Instruction fetch front end for the Tinker core. It generates sequential 32-bit fetch requests toward instruction memory and buffers the returned words with their PCs in an in-order queue. It presents them to the decode/control stage through a valid/ready handshake. A redirect from control (taken branch, call, return) flushes the queue, discards in-flight responses and restarts fetch at the new PC.

## Interface
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, ≥ 2
- RESET_PC, 32'h00002000, first fetch address after reset
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- memReqValid  output  1  fetch request valid
- memReqReady  input  1  memory accepts request this cycle
- memReqAddr  output  32  word-aligned fetch address
- memRespValid  input  1  response word valid; responses return in request order, ≥1 cycle after acceptance
- memRespData  input  32  instruction word, already assembled little-endian
- instValid  output  1  head instruction valid for decode
- instReady  input  1  decode consumes head this cycle
- instWord  output  32  head instruction
- instPc  output  32  PC of head instruction
- redirectValid  input  1  flush and restart fetch
- redirectPc  input  32  restart address; bits [1:0] ignored, treated as 0

## Operation
- State: fetchPc (next request address), respPc (PC of next live response), queue of DEPTH {word, pc} entries with head/tail pointers and occupancy, inFlight (accepted requests not yet answered), dropCount (in-flight responses known stale). Counters are $clog2(DEPTH)+1 bits wide.
- memReqValid = !redirectValid && (occupancy + inFlight < DEPTH). memReqAddr = fetchPc.
- Request handshake (memReqValid && memReqReady): fetchPc += 4, inFlight += 1.
- Response with dropCount > 0: word discarded, dropCount −= 1, inFlight −= 1.
- Response with dropCount == 0: {memRespData, respPc} written at tail, occupancy += 1, respPc += 4, inFlight −= 1.
- Response with inFlight == 0 is a protocol violation and is ignored; no state changes.
- instValid = (occupancy > 0) && !redirectValid. instWord and instPc come from the head entry. A pop on instValid && instReady advances head and decrements occupancy.
- Redirect cycle:
  - queue emptied (occupancy 0, head = tail)
  - fetchPc = respPc = {redirectPc[31:2], 2'b00}
  - no request is issued and no pop occurs
  - a response arriving in the same cycle is discarded
  - dropCount = inFlight after that cycle's response, if any, is removed
- Redirect has priority over push, pop and request in the same cycle.
- Push and pop in the same cycle leave occupancy unchanged. The credit rule guarantees no push into a full queue.
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.

## Timing
- Reset asserted (reset = 0), asynchronously:
  - fetchPc = respPc = RESET_PC
  - occupancy = inFlight = dropCount = 0
  - queue entries = 0
  - memReqValid = 0, instValid = 0, instWord = 0, instPc = 0, memReqAddr = RESET_PC
- Reset mid-operation discards all queued and in-flight state. Memory is expected to drop its outstanding responses on the same reset.
- First rising edge after release: memReqValid = 1 with memReqAddr = RESET_PC.
- Latency: a response accepted in cycle N gives instValid in cycle N+1. There is no bypass from response to output.
- Throughput: one request, one response and one pop per cycle. With single-cycle memory and instReady held at 1, one instruction is delivered per cycle.
- instValid and memReqValid depend combinationally on redirectValid. All other outputs are registered state.

## Test plan
- Reset release, memory answering 1 cycle after each request, instReady = 1 -> requests 0x2000, 0x2004, 0x2008…; instPc sequence 0x2000, 0x2004… one per cycle, instWord matching memory contents.
- instReady = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests accepted, occupancy reaches 4, memReqValid stays 0. On instReady = 1, the 4 words pop in order and fetch resumes.
- 3 requests in flight (memory latency 5), redirectValid with redirectPc = 0x3001 -> next request is 0x3000. The 3 stale responses are discarded, and the first instPc after the redirect is 0x3000.
- Redirect in the same cycle as a response and instValid = 1 with instReady = 1 -> no pop and no push; queue empty next cycle; dropCount = remaining inFlight.
- Redirect to 0xFFFFFFF8 -> instPc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Drive reset low while the queue holds 2 entries and 1 request is in flight -> instValid = 0 and memReqValid = 0 immediately, with no clock edge needed. After release, fetch restarts at 0x2000 with no stale instruction delivered.
